adj_tick_timer: RTL and testbench
=================================

Name: adj_tick_timer

Overview:
- Downstream consumer of the adjustable divided clock. Takes the slow divided clock level (e.g. ClkOutput of the static divider) as a plain data input.
- Synchronises it into the ClkInput domain and converts its edges into single-cycle tick strobes.
- Drives a loadable countdown timer with start/stop control and expiry signalling, so logic can stay on ClkInput and use the slow clock as an enable.

Parameters:
- COUNT_WIDTH, 16: width of the countdown counter and load value.
- BOTH_EDGES, 0: 0 = tick on SlowClkInput rising edges only; 1 = tick on rising and falling edges.

Ports:
- ClkInput  input  1  system clock; all logic on its posedge.
- ResetInput  input  1  synchronous, active-high reset.
- SlowClkInput  input  1  divided clock level; may be asynchronous to ClkInput.
- LoadInput  input  1  load strobe.
- LoadValueInput  input  COUNT_WIDTH  value captured on LoadInput.
- StartInput  input  1  start/resume strobe.
- StopInput  input  1  pause strobe.
- TickOutput  output  1  one-cycle strobe per detected SlowClkInput edge.
- CountOutput  output  COUNT_WIDTH  current count.
- RunningOutput  output  1  high in RUNNING.
- ExpiredOutput  output  1  high in EXPIRED.
- DoneOutput  output  1  one-cycle pulse on reaching zero.

Behaviour:
- Reset (sampled on ClkInput posedge while ResetInput=1):
  - Outputs: TickOutput=0, CountOutput=0, RunningOutput=0, ExpiredOutput=0, DoneOutput=0.
  - Internal: state=IDLE, sync/prev registers=0, reload register=0, arm counter=0.
  - Reset mid-operation aborts everything immediately.
- Synchroniser and tick generation:
  - 2-FF synchroniser followed by a prev register; TickOutput is registered.
  - Edge sampled at posedge N: sync1 updates at N, sync2 at N+1, TickOutput=1 for the cycle after posedge N+2.
  - Latency is 3 ClkInput edges; TickOutput is high for exactly one cycle per qualifying edge.
  - Ticks are suppressed until 3 posedges after reset release (arm counter), so a SlowClkInput already high at reset produces no spurious tick.
  - SlowClkInput high or low time must be ≥2 ClkInput cycles. Shorter pulses may be lost; no further guarantee.
- States:
  - IDLE: counting inhibited.
  - RUNNING: counting down.
  - PAUSED: counting inhibited, count held.
  - EXPIRED: count=0, held.
- Per-edge priority: Reset > Load > Stop > Start > tick.
- Load (any state):
  - CountOutput and reload register take LoadValueInput.
  - State goes to IDLE.
  - A DoneOutput pending that cycle is cancelled.
- Stop:
  - In RUNNING: go to PAUSED; a coincident tick is discarded (count unchanged).
  - In other states: no effect.
- Start:
  - In IDLE or PAUSED with CountOutput≠0: go to RUNNING. The first decrement is on the next tick; a tick coincident with Start is ignored.
  - In IDLE or PAUSED with CountOutput=0: no effect.
  - In RUNNING or EXPIRED: no effect.
- Tick (the edge at which TickOutput=1) in RUNNING:
  - CountOutput decrements by 1.
  - If CountOutput was 1: it becomes 0, state goes to EXPIRED, and DoneOutput=1 for the following cycle.
- Arithmetic:
  - Count is unsigned and never decrements below 0; no wrap.
  - LoadValueInput of all-ones is legal, giving 2^COUNT_WIDTH−1 ticks.
- Ticks in IDLE, PAUSED or EXPIRED are visible on TickOutput but do not change the count.
- RunningOutput and ExpiredOutput are registered decodes of the state, valid in the same cycle as the state.

Optional Feature:
- Macro: LIB_STYCZYNSKI_ADJ_TICK_TIMER_AUTORELOAD_EN.
- Defined:
  - On the expiry tick, CountOutput reloads from the reload register instead of becoming 0.
  - State stays RUNNING; DoneOutput still pulses one cycle.
  - EXPIRED is never entered; ExpiredOutput is tied 0.
  - Stop and Load behave as above.
- Undefined: behaviour exactly as in Behaviour; the reload register may be optimised away.

Test Plan:
1. Reset, SlowClkInput held 1 through reset release → no TickOutput for 20 cycles; all outputs 0.
2. BOTH_EDGES=0, SlowClkInput rises sampled at posedge 10 → TickOutput=1 only in the cycle after posedge 12; with BOTH_EDGES=1 the falling edge also ticks, with the same 3-edge latency.
3. Load 3, Start, 3 ticks → CountOutput 3→2→1→0; DoneOutput one cycle after the 3rd tick; ExpiredOutput=1, RunningOutput=0; a 4th tick leaves count at 0.
4. Load 5, Start, 2 ticks, Stop coincident with the 3rd tick → count=3, PAUSED; Start, 3 ticks → Done; Start while count=0 in IDLE → no change.
5. Load 4 and Stop and Start all asserted on the same edge as a tick while RUNNING at count 2 → count=4, state IDLE, no DoneOutput.
6. AUTORELOAD_EN: Load 2, Start, 6 ticks → count 2,1,2,1,2,1,2 and three DoneOutput pulses; ExpiredOutput stays 0; ResetInput asserted mid-run → all outputs 0 next cycle.

Source files
------------

// File: rtl/adj_tick_timer_if.sv
// Signal bundle between a controller and adj_tick_timer: slow clock level,
// timer control strobes and the tick/count/status outputs.
interface adj_tick_timer_if #(
  parameter int COUNT_WIDTH = 16
);
  logic                   SlowClkInput;
  logic                   LoadInput;
  logic [COUNT_WIDTH-1:0] LoadValueInput;
  logic                   StartInput;
  logic                   StopInput;
  logic                   TickOutput;
  logic [COUNT_WIDTH-1:0] CountOutput;
  logic                   RunningOutput;
  logic                   ExpiredOutput;
  logic                   DoneOutput;

  modport master (
    output SlowClkInput, LoadInput, LoadValueInput, StartInput, StopInput,
    input  TickOutput, CountOutput, RunningOutput, ExpiredOutput, DoneOutput
  );

  modport slave (
    input  SlowClkInput, LoadInput, LoadValueInput, StartInput, StopInput,
    output TickOutput, CountOutput, RunningOutput, ExpiredOutput, DoneOutput
  );
endinterface

// File: rtl/adj_tick_timer.sv
// Slow-clock edge ticker driving a loadable countdown timer on ClkInput.
// Define LIB_STYCZYNSKI_ADJ_TICK_TIMER_AUTORELOAD_EN to reload on expiry instead of stopping.
module adj_tick_timer #(
  parameter int COUNT_WIDTH = 16,
  parameter bit BOTH_EDGES  = 1'b0
) (
  input  logic             ClkInput,
  input  logic             ResetInput,
  adj_tick_timer_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RUNNING, PAUSED, EXPIRED} state_t;

  state_t                 state_q, state_n;
  logic                   sync1_q, sync2_q, prev_q;
  logic [1:0]             arm_q;
  logic                   tick_q;
  logic [COUNT_WIDTH-1:0] count_q, count_n;
  logic                   running_q, expired_q;
  logic                   done_q, done_n;
  logic                   edge_det;
  logic                   armed;
`ifdef LIB_STYCZYNSKI_ADJ_TICK_TIMER_AUTORELOAD_EN
  logic [COUNT_WIDTH-1:0] reload_q, reload_n;
`endif

  assign edge_det = BOTH_EDGES ? (sync2_q ^ prev_q) : (sync2_q & ~prev_q);
  // prev starts at 0, so a level already high at reset would look like an edge on the third posedge
  assign armed    = (arm_q == 2'd3);

  always_comb begin
    state_n = state_q;
    count_n = count_q;
    done_n  = 1'b0;
`ifdef LIB_STYCZYNSKI_ADJ_TICK_TIMER_AUTORELOAD_EN
    reload_n = reload_q;
`endif
    if (bus.LoadInput) begin
      count_n = bus.LoadValueInput;
      state_n = IDLE;
`ifdef LIB_STYCZYNSKI_ADJ_TICK_TIMER_AUTORELOAD_EN
      reload_n = bus.LoadValueInput;
`endif
    end else if (bus.StopInput && state_q == RUNNING) begin
      state_n = PAUSED;
    end else if (bus.StartInput && (state_q == IDLE || state_q == PAUSED)) begin
      if (count_q != '0) state_n = RUNNING;
    end else if (tick_q && state_q == RUNNING && count_q != '0) begin
      if (count_q == COUNT_WIDTH'(1)) begin
        done_n = 1'b1;
`ifdef LIB_STYCZYNSKI_ADJ_TICK_TIMER_AUTORELOAD_EN
        count_n = reload_q;
`else
        count_n = '0;
        state_n = EXPIRED;
`endif
      end else begin
        count_n = count_q - COUNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge ClkInput) begin
    if (ResetInput) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      prev_q    <= 1'b0;
      arm_q     <= 2'd0;
      tick_q    <= 1'b0;
      state_q   <= IDLE;
      count_q   <= '0;
      running_q <= 1'b0;
      expired_q <= 1'b0;
      done_q    <= 1'b0;
`ifdef LIB_STYCZYNSKI_ADJ_TICK_TIMER_AUTORELOAD_EN
      reload_q  <= '0;
`endif
    end else begin
      sync1_q   <= bus.SlowClkInput;
      sync2_q   <= sync1_q;
      prev_q    <= sync2_q;
      if (!armed) arm_q <= arm_q + 2'd1;
      tick_q    <= armed & edge_det;
      state_q   <= state_n;
      count_q   <= count_n;
      running_q <= (state_n == RUNNING);
      expired_q <= (state_n == EXPIRED);
      done_q    <= done_n;
`ifdef LIB_STYCZYNSKI_ADJ_TICK_TIMER_AUTORELOAD_EN
      reload_q  <= reload_n;
`endif
    end
  end

  assign bus.TickOutput    = tick_q;
  assign bus.CountOutput   = count_q;
  assign bus.RunningOutput = running_q;
  assign bus.ExpiredOutput = expired_q;
  assign bus.DoneOutput    = done_q;

endmodule

// File: tb/tb_adj_tick_timer.sv
// Randomized scoreboard bench for adj_tick_timer: rising-only and both-edge
// instances share stimulus and are checked against a behavioural model.
module tb_adj_tick_timer;
  localparam int CW = 8;

  typedef struct packed {
    logic          tick;
    logic [CW-1:0] count;
    logic          running;
    logic          expired;
    logic          done;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  adj_tick_timer_if #(.COUNT_WIDTH(CW)) bus0 ();
  adj_tick_timer_if #(.COUNT_WIDTH(CW)) bus1 ();

  adj_tick_timer #(.COUNT_WIDTH(CW), .BOTH_EDGES(1'b0)) dut0 (
    .ClkInput(clk), .ResetInput(rst), .bus(bus0.slave));
  adj_tick_timer #(.COUNT_WIDTH(CW), .BOTH_EDGES(1'b1)) dut1 (
    .ClkInput(clk), .ResetInput(rst), .bus(bus1.slave));

  exp_t q0[$];
  exp_t q1[$];
  int   checks   = 0;
  int   failures = 0;
  bit   started  = 1'b0;
  int   cyc      = 0;

  // reference model: mode 0 idle, 1 running, 2 paused, 3 expired
  int      n;
  bit      samp[$];
  int      m_mode[2];
  int      m_cnt[2];
  int      m_reload[2];
  bit      m_tick[2];
  bit      m_done[2];

  // slow clock source
  bit slow = 1'b0;
  bit slow_force = 1'b0;
  int hold = 3;

  function automatic exp_t snap(int b);
    exp_t e;
    e.tick    = m_tick[b];
    e.count   = CW'(m_cnt[b]);
    e.running = (m_mode[b] == 1);
    e.expired = (m_mode[b] == 3);
    e.done    = m_done[b];
    return e;
  endfunction

  task automatic step(input bit r, input bit ld, input int lv,
                      input bit st, input bit sp);
    bit s;
    bit tn;
    @(negedge clk);
    if (slow_force) s = 1'b1;
    else begin
      s = slow;
      hold--;
      if (hold == 0) begin
        slow = ~slow;
        hold = $urandom_range(2, 6);
      end
    end
    rst = r;
    bus0.SlowClkInput = s;   bus1.SlowClkInput = s;
    bus0.LoadInput = ld;     bus1.LoadInput = ld;
    bus0.LoadValueInput = CW'(lv); bus1.LoadValueInput = CW'(lv);
    bus0.StartInput = st;    bus1.StartInput = st;
    bus0.StopInput = sp;     bus1.StopInput = sp;
    if (r) begin
      n = 0;
      samp.delete();
      samp.push_back(1'b0);
      for (int b = 0; b < 2; b++) begin
        m_mode[b] = 0; m_cnt[b] = 0; m_reload[b] = 0;
        m_tick[b] = 0; m_done[b] = 0;
      end
    end else begin
      n++;
      samp.push_back(s);
      for (int b = 0; b < 2; b++) begin
        // an edge seen at sample k appears on the tick output after posedge k+2
        if (n >= 4)
          tn = (b == 1) ? (samp[n-2] != samp[n-3]) : (samp[n-2] && !samp[n-3]);
        else
          tn = 1'b0;
        m_done[b] = 1'b0;
        if (ld) begin
          m_cnt[b] = lv; m_reload[b] = lv; m_mode[b] = 0;
        end else if (sp && m_mode[b] == 1) begin
          m_mode[b] = 2;
        end else if (st && (m_mode[b] == 0 || m_mode[b] == 2)) begin
          if (m_cnt[b] != 0) m_mode[b] = 1;
        end else if (m_tick[b] && m_mode[b] == 1) begin
          m_cnt[b] = m_cnt[b] - 1;
          if (m_cnt[b] == 0) begin
            m_done[b] = 1'b1;
`ifdef LIB_STYCZYNSKI_ADJ_TICK_TIMER_AUTORELOAD_EN
            m_cnt[b] = m_reload[b];
`else
            m_mode[b] = 3;
`endif
          end
        end
        m_tick[b] = tn;
      end
    end
    q0.push_back(snap(0));
    q1.push_back(snap(1));
    started = 1'b1;
  endtask

  task automatic compare(input int b, input exp_t got, input exp_t want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL dut%0d cycle %0d got tick=%b count=%0d run=%b expd=%b done=%b want tick=%b count=%0d run=%b expd=%b done=%b",
               b, cyc, got.tick, got.count, got.running, got.expired, got.done,
               want.tick, want.count, want.running, want.expired, want.done);
    end
  endtask

  // monitor: outputs are presented every cycle, so one expectation per posedge
  initial begin
    exp_t g;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (q0.size() > 0 && q1.size() > 0) begin
        g = {bus0.TickOutput, bus0.CountOutput, bus0.RunningOutput,
             bus0.ExpiredOutput, bus0.DoneOutput};
        compare(0, g, q0.pop_front());
        g = {bus1.TickOutput, bus1.CountOutput, bus1.RunningOutput,
             bus1.ExpiredOutput, bus1.DoneOutput};
        compare(1, g, q1.pop_front());
      end else if (started) begin
        checks++;
        failures++;
        $display("FAIL scoreboard_empty cycle %0d got q0=%0d q1=%0d want nonzero",
                 cyc, q0.size(), q1.size());
      end
    end
  end

  initial begin
    int lv;
    bus0.SlowClkInput = 0; bus1.SlowClkInput = 0;
    bus0.LoadInput = 0; bus1.LoadInput = 0;
    bus0.LoadValueInput = '0; bus1.LoadValueInput = '0;
    bus0.StartInput = 0; bus1.StartInput = 0;
    bus0.StopInput = 0; bus1.StopInput = 0;

    // slow level high through reset release: no tick allowed
    slow_force = 1'b1;
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) step(0, 0, 0, 0, 0);
    slow_force = 1'b0;
    slow = 1'b0;
    hold = 4;

    // load 3, start, run to expiry and beyond
    step(0, 1, 3, 0, 0);
    step(0, 0, 0, 1, 0);
    for (int i = 0; i < 60; i++) step(0, 0, 0, 0, 0);
    // start at count 0 in idle
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 0);
    // load 5, start, pause, resume
    step(0, 1, 5, 0, 0);
    step(0, 0, 0, 1, 0);
    for (int i = 0; i < 12; i++) step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    for (int i = 0; i < 40; i++) step(0, 0, 0, 0, 0);

    // random traffic, including coincident load/stop/start and mid-run reset
    for (int i = 0; i < 3000; i++) begin
      int r;
      r = $urandom_range(0, 999);
      case ($urandom_range(0, 3))
        0: lv = $urandom_range(0, 2);
        1: lv = (1 << CW) - 1;
        default: lv = $urandom_range(1, 6);
      endcase
      if (r < 3)        step(1, 0, 0, 0, 0);
      else if (r < 25)  step(0, 1, lv, 1, 1);
      else if (r < 50)  step(0, 1, lv, 0, 0);
      else if (r < 130) step(0, 0, 0, 1, 0);
      else if (r < 160) step(0, 0, 0, 0, 1);
      else if (r < 175) step(0, 0, 0, 1, 1);
      else              step(0, 0, 0, 0, 0);
    end

    @(posedge clk);
    #2;
    started = 1'b0;
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got q0=%0d q1=%0d want 0", q0.size(), q1.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
